// File: rtl/output_interface.sv
// Ciphertext return path: captures a finished block on the engine's done edge
// and serialises it MSB-first over a valid/ack byte port, with one pending slot.
module output_interface #(
    parameter int BYTE_W      = 8,
    parameter int BLOCK_BYTES = 16
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          transformer_done,
    input  logic [BYTE_W*BLOCK_BYTES-1:0] cipher_in,
    output logic [BYTE_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ack,
    output logic                          tx_done,
    output logic                          ready,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    localparam int BLOCK_W = BYTE_W * BLOCK_BYTES;
    localparam int CNT_W   = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_BYTES - 1);

    typedef enum logic [1:0] {
        S_ID = 2'd0,
        S_TX = 2'd1,
        S_DN = 2'd2
    } state_t;

    state_t               state;
    logic [BLOCK_W-1:0]   shift;
    logic [BLOCK_W-1:0]   pend;
    logic                 pend_vld;
    logic [CNT_W-1:0]     cnt;
    logic                 done_q;
    logic                 rise;
    logic                 drop;

    assign rise = transformer_done && !done_q;
    // A rise outside idle can only be parked; with the slot already full it is lost.
    assign drop = rise && (state != S_ID) && pend_vld;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state    <= S_ID;
            shift    <= '0;
            cnt      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            done_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done_q <= transformer_done;
            case (state)
                S_ID: begin
                    if (pend_vld) begin
                        shift <= pend;
                        cnt   <= '0;
                        state <= S_TX;
                        if (rise) begin
                            pend <= cipher_in;
                        end else begin
                            pend_vld <= 1'b0;
                        end
                    end else if (rise) begin
                        shift <= cipher_in;
                        cnt   <= '0;
                        state <= S_TX;
                    end
                end
                S_TX: begin
                    if (dout_ack) begin
                        if (cnt == LAST) begin
                            state <= S_DN;
                        end else begin
                            shift <= shift << BYTE_W;
                            cnt   <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DN: state <= S_ID;
                default: state <= S_ID;
            endcase

            if (rise && (state != S_ID) && !pend_vld) begin
                pend     <= cipher_in;
                pend_vld <= 1'b1;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign dout_valid = (state == S_TX);
    assign tx_done    = (state == S_DN);
    assign dout       = dout_valid ? shift[BLOCK_W-1 -: BYTE_W] : '0;
    assign ready      = !pend_vld;

endmodule

// File: tb/tb_output_interface.sv
// Directed bench for output_interface: byte order, ack throttling, level vs edge,
// pending buffer, overflow/clear and mid-block reset.
module tb_output_interface;

    logic         clk = 1'b0;
    logic         rst_;
    logic         transformer_done;
    logic [127:0] cipher_in;
    logic [7:0]   dout;
    logic         dout_valid;
    logic         dout_ack;
    logic         tx_done;
    logic         ready;
    logic         overflow;
    logic         ovf_clr;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] BLK_SEQ = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] BLK_X   = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] BLK_A   = 128'hF00DBABEDEADBEEF0123456789ABCDEF;
    localparam logic [127:0] BLK_B   = 128'h3AD77BB40D7A3660A89ECAF32466EF97;
    localparam logic [127:0] BLK_C   = 128'hCCCCCCCC5555555533333333AAAAAAAA;

    always #5 clk = ~clk;

    output_interface #(.BYTE_W(8), .BLOCK_BYTES(16)) dut (
        .clk              (clk),
        .rst_             (rst_),
        .transformer_done (transformer_done),
        .cipher_in        (cipher_in),
        .dout             (dout),
        .dout_valid       (dout_valid),
        .dout_ack         (dout_ack),
        .tx_done          (tx_done),
        .ready            (ready),
        .overflow         (overflow),
        .ovf_clr          (ovf_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
        return v[127 - 8*k -: 8];
    endfunction

    // Checks a block whose byte 0 is already on dout, with ack held high.
    task automatic run_block(input string tag, input logic [127:0] blk);
        for (int k = 0; k < 16; k++) begin
            chk({tag, "_valid"}, 128'(dout_valid), 128'(1));
            chk({tag, "_byte"}, 128'(dout), 128'(byte_of(blk, k)));
            tick;
        end
        chk({tag, "_txdone"}, 128'(tx_done), 128'(1));
        chk({tag, "_dn_valid"}, 128'(dout_valid), 128'(0));
    endtask

    initial begin
        logic [127:0] got;
        int nbytes;
        int ntx;

        rst_ = 1'b1; transformer_done = 1'b0; cipher_in = '0; dout_ack = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick;
        chk("rst_valid", 128'(dout_valid), 128'(0));
        chk("rst_dout", 128'(dout), 128'(0));
        chk("rst_txdone", 128'(tx_done), 128'(0));
        chk("rst_ready", 128'(ready), 128'(1));
        chk("rst_ovf", 128'(overflow), 128'(0));
        rst_ = 1'b0;
        tick;

        // Sequential block, ack always high.
        cipher_in = BLK_SEQ; transformer_done = 1'b1; dout_ack = 1'b1;
        tick;
        transformer_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("seq_byte", 128'(dout), 128'(k));
            chk("seq_ready", 128'(ready), 128'(1));
            tick;
        end
        chk("seq_txdone", 128'(tx_done), 128'(1));
        chk("seq_dn_dout", 128'(dout), 128'(0));
        tick;
        chk("seq_txdone_once", 128'(tx_done), 128'(0));
        chk("seq_idle_valid", 128'(dout_valid), 128'(0));

        // Same block, ack only every third cycle.
        dout_ack = 1'b0; transformer_done = 1'b1;
        tick;
        transformer_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            repeat (2) begin
                chk("slow_hold", 128'(dout), 128'(k));
                chk("slow_notx", 128'(tx_done), 128'(0));
                tick;
            end
            dout_ack = 1'b1;
            chk("slow_byte", 128'(dout), 128'(k));
            tick;
            dout_ack = 1'b0;
        end
        chk("slow_txdone", 128'(tx_done), 128'(1));
        tick;
        chk("slow_txdone_once", 128'(tx_done), 128'(0));

        // Done held high: level must not retrigger.
        cipher_in = BLK_X; transformer_done = 1'b1; dout_ack = 1'b1;
        got = '0; nbytes = 0; ntx = 0;
        repeat (40) begin
            tick;
            if (dout_valid) begin
                got = {got[119:0], dout};
                nbytes++;
            end
            if (tx_done) ntx++;
        end
        transformer_done = 1'b0;
        chk("lvl_nbytes", 128'(nbytes), 128'(16));
        chk("lvl_ntx", 128'(ntx), 128'(1));
        chk("lvl_data", got, BLK_X);
        tick;
        chk("lvl_idle", 128'(dout_valid), 128'(0));

        // B arrives during A at byte 5 and waits in the pending slot.
        cipher_in = BLK_A; transformer_done = 1'b1;
        tick;
        transformer_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("pend_a_byte", 128'(dout), 128'(byte_of(BLK_A, k)));
            if (k == 5) begin
                transformer_done = 1'b1; cipher_in = BLK_B;
            end
            if (k == 6) begin
                transformer_done = 1'b0; cipher_in = BLK_C;
                chk("pend_ready_lo", 128'(ready), 128'(0));
            end
            tick;
        end
        chk("pend_a_txdone", 128'(tx_done), 128'(1));
        chk("pend_ready_dn", 128'(ready), 128'(0));
        tick;
        chk("pend_gap_valid", 128'(dout_valid), 128'(0));
        chk("pend_gap_ready", 128'(ready), 128'(0));
        tick;
        chk("pend_b_ready", 128'(ready), 128'(1));
        run_block("pend_b", BLK_B);
        tick;

        // B and C during A: C dropped; clear collides with the drop, then clears alone.
        cipher_in = BLK_A; transformer_done = 1'b1;
        tick;
        transformer_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("ovf_a_byte", 128'(dout), 128'(byte_of(BLK_A, k)));
            if (k == 2) begin transformer_done = 1'b1; cipher_in = BLK_B; end
            if (k == 3) begin
                transformer_done = 1'b0; cipher_in = '0;
                chk("ovf_not_yet", 128'(overflow), 128'(0));
            end
            if (k == 5) begin transformer_done = 1'b1; cipher_in = BLK_C; ovf_clr = 1'b1; end
            if (k == 6) begin
                transformer_done = 1'b0; ovf_clr = 1'b0;
                chk("ovf_set_wins", 128'(overflow), 128'(1));
            end
            tick;
        end
        tick;
        tick;
        for (int k = 0; k < 16; k++) begin
            chk("ovf_b_byte", 128'(dout), 128'(byte_of(BLK_B, k)));
            if (k == 2) ovf_clr = 1'b1;
            if (k == 3) begin
                ovf_clr = 1'b0;
                chk("ovf_cleared", 128'(overflow), 128'(0));
            end
            tick;
        end
        chk("ovf_b_txdone", 128'(tx_done), 128'(1));
        repeat (3) begin
            tick;
            chk("ovf_no_c", 128'(dout_valid), 128'(0));
        end

        // Reset mid-block with pend full and overflow set.
        cipher_in = BLK_A; transformer_done = 1'b1;
        tick;
        transformer_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("mrst_a_byte", 128'(dout), 128'(byte_of(BLK_A, k)));
            if (k == 2) begin transformer_done = 1'b1; cipher_in = BLK_B; end
            if (k == 3) transformer_done = 1'b0;
            if (k == 4) begin transformer_done = 1'b1; cipher_in = BLK_C; end
            if (k == 5) transformer_done = 1'b0;
            if (k == 6) chk("mrst_ovf_pre", 128'(overflow), 128'(1));
            if (k == 7) rst_ = 1'b1;
            if (k < 7) tick;
        end
        tick;
        rst_ = 1'b0;
        chk("mrst_valid", 128'(dout_valid), 128'(0));
        chk("mrst_dout", 128'(dout), 128'(0));
        chk("mrst_txdone", 128'(tx_done), 128'(0));
        chk("mrst_ready", 128'(ready), 128'(1));
        chk("mrst_ovf", 128'(overflow), 128'(0));
        repeat (2) begin
            tick;
            chk("mrst_idle", 128'(dout_valid), 128'(0));
            chk("mrst_no_txdone", 128'(tx_done), 128'(0));
        end
        cipher_in = BLK_X; transformer_done = 1'b1;
        tick;
        transformer_done = 1'b0;
        run_block("mrst_x", BLK_X);
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/output_interface.md
Name: output_interface

Overview:
- Return path of the AES engine.
- Captures the 128-bit ciphertext when the transformer signals completion, then serialises it to the host as 16 bytes over an 8-bit valid/ack byte port.
- Bytes go out MSB-first, the same order the input side loads plaintext, so byte 0 out is cipher[127:120].
- A one-block pending buffer lets the engine finish the next block while the current one is still being transmitted.

Parameters:
- BYTE_W, 8, width of the host data port.
- BLOCK_BYTES, 16, bytes per block; the block width is BYTE_W*BLOCK_BYTES = 128.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_  input  1  one clock; reset is synchronous and active-high (rst_=1 resets).
- transformer_done  input  1  engine done level; a capture happens on its rising edge only.
- cipher_in  input  128  ciphertext, valid while transformer_done is high.
- dout  output  8  current byte; forced to 0 when dout_valid=0.
- dout_valid  output  1  byte on dout is valid.
- dout_ack  input  1  host accepts the byte; a transfer occurs on a cycle with dout_valid && dout_ack.
- tx_done  output  1  one-cycle pulse after the 16th byte is accepted.
- ready  output  1  pending buffer empty, so a new block can be accepted without loss.
- overflow  output  1  sticky; a block was dropped.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset values: state=S_ID, shift=0, cnt=0, pend=0, pend_vld=0, done_q=0, overflow=0. Outputs after reset: dout=0, dout_valid=0, tx_done=0, ready=1.
- Edge detect:
  - done_q <= transformer_done every cycle; rise = transformer_done && !done_q.
  - Because done_q resets to 0, a done that is already high when reset releases counts as a rise.
- States: S_ID (idle), S_TX (transmit), S_DN (done pulse).
- S_ID:
  - If pend_vld: shift<=pend, pend_vld<=0, cnt<=0, go to S_TX.
  - Else if rise: shift<=cipher_in, cnt<=0, go to S_TX.
  - If pend_vld && rise in the same cycle: pend loads into shift, and cipher_in is captured into pend with pend_vld staying 1.
- S_TX:
  - dout_valid=1 and dout=shift[127:120].
  - Transfer with cnt<15: shift<=shift<<8, cnt<=cnt+1.
  - Transfer with cnt==15: go to S_DN.
  - No ack: hold dout and cnt.
- S_DN:
  - tx_done=1 and dout_valid=0 for exactly one cycle.
  - Next state is always S_ID.
  - Pending data is loaded one cycle later from S_ID, so back-to-back blocks have exactly 2 idle cycles between the last ack and the next dout_valid.
- Rise while in S_TX or S_DN:
  - pend_vld=0: pend<=cipher_in, pend_vld<=1.
  - pend_vld=1: block dropped, overflow<=1, pend unchanged.
- overflow:
  - ovf_clr clears it.
  - If ovf_clr and a new overflow occur in the same cycle, set wins.
- ready = !pend_vld (combinational).
- Latency:
  - Rise at edge N in S_ID → dout_valid=1 with byte 0 after edge N.
  - With ack held high, byte k is accepted at edge N+1+k.
  - tx_done is high in the cycle after edge N+16.
- cnt is 4 bits; it wraps to 0 only on reload, never inside a block.
- Reset mid-block: everything, including pend and overflow, returns to reset values at the next edge. The partial block is discarded and no tx_done is generated.
- dout_ack while dout_valid=0 is ignored.

Test Plan:
- cipher_in=128'h000102…0F, one rise, dout_ack held 1 → dout sequence 00,01,…,0F on 16 consecutive cycles; tx_done pulses once; ready stays 1.
- Same block with ack asserted every 3rd cycle → each byte held stable until acked; still 16 bytes, correct order, single tx_done.
- transformer_done held high for 40 cycles → exactly one block transmitted (level does not retrigger).
- Block A=128'hF00DBABE… transmitting; rise with B=128'h3AD77BB4… at byte 5 → ready=0; A completes; B starts 2 cycles after tx_done; ready returns to 1 when B loads.
- Rises for B and C during A → C dropped, overflow=1; ovf_clr pulse → overflow=0; only A and B emitted.
- rst_=1 at byte 7 → next cycle dout_valid=0, dout=0, tx_done=0, ready=1, overflow=0; a new rise transmits a fresh block from byte 0.
